// File: rtl/iterative_compare_unit.sv
// Multi-cycle eq/ne/lt/ge/ltu/geu comparator: scans CHUNK-bit slices from the MSB
// down, one per clock, with valid/ready handshakes on both sides.

package Types;
  typedef struct packed {
    logic mode;  // 0 = equality, 1 = ordering
    logic un;    // 1 = unsigned ordering
    logic neg;   // invert the selected flag
  } comparison_op_t;
endpackage

module iterative_compare_unit #(
  parameter int WIDTH      = 32,
  parameter int CHUNK      = 8,
  parameter bit EARLY_EXIT = 1'b1
) (
  input  logic                 clk,
  input  logic                 reset,
  input  logic                 in_valid,
  output logic                 in_ready,
  input  logic [WIDTH-1:0]     a,
  input  logic [WIDTH-1:0]     b,
  input  Types::comparison_op_t op,
  output logic                 out_valid,
  input  logic                 out_ready,
  output logic                 result,
  output logic                 eq,
  output logic                 lt,
  output logic                 busy
);

  localparam int NCHUNK = WIDTH / CHUNK;
  localparam int IDXW   = (NCHUNK > 1) ? $clog2(NCHUNK) : 1;

  generate
    if (CHUNK < 1 || (WIDTH % CHUNK) != 0) begin : g_bad_cfg
      $error("iterative_compare_unit: WIDTH must be a positive multiple of CHUNK");
    end
  endgenerate

  typedef enum logic [1:0] {IDLE, SCAN, DONE} state_t;

  state_t            state_reg, state_next;
  logic [WIDTH-1:0]  a_reg, b_reg;
  logic              mode_reg, neg_reg;
  logic [IDXW-1:0]   idx_reg;
  logic              miss_seen_reg, miss_lt_reg;
  logic              eq_reg, lt_reg, result_reg;

  logic [WIDTH-1:0]  sign_flip;
  logic [CHUNK-1:0]  a_slices [NCHUNK];
  logic [CHUNK-1:0]  b_slices [NCHUNK];
  logic [CHUNK-1:0]  cur_a, cur_b;
  logic              slice_diff, slice_lt, slice_last;
  logic              fin_eq, fin_lt;

  // Signed ordering becomes unsigned ordering once both sign bits are flipped.
  always_comb begin
    sign_flip            = '0;
    sign_flip[WIDTH-1]   = op.mode & ~op.un;
  end

  // Slice 0 is the most significant slice.
  generate
    for (genvar gi = 0; gi < NCHUNK; gi++) begin : g_slice
      assign a_slices[gi] = a_reg[WIDTH-1-gi*CHUNK -: CHUNK];
      assign b_slices[gi] = b_reg[WIDTH-1-gi*CHUNK -: CHUNK];
    end
  endgenerate

  always_comb begin
    cur_a = '0;
    cur_b = '0;
    for (int i = 0; i < NCHUNK; i++) begin
      if (idx_reg == IDXW'(i)) begin
        cur_a = a_slices[i];
        cur_b = b_slices[i];
      end
    end
  end

  assign slice_diff = (cur_a != cur_b);
  assign slice_lt   = (cur_a < cur_b);
  assign slice_last = (idx_reg == IDXW'(NCHUNK - 1));

  // The first mismatching slice alone decides the ordering.
  always_comb begin
    fin_eq = 1'b1;
    fin_lt = 1'b0;
    if (miss_seen_reg) begin
      fin_eq = 1'b0;
      fin_lt = miss_lt_reg;
    end else if (slice_diff) begin
      fin_eq = 1'b0;
      fin_lt = slice_lt;
    end
  end

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      state_reg <= IDLE;
    end else begin
      state_reg <= state_next;
    end
  end

  always_comb begin
    state_next = state_reg;
    case (state_reg)
      IDLE: if (in_valid) state_next = SCAN;
      SCAN: if ((EARLY_EXIT && slice_diff) || slice_last) state_next = DONE;
      DONE: if (out_ready) state_next = IDLE;
      default: state_next = IDLE;
    endcase
  end

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      a_reg         <= '0;
      b_reg         <= '0;
      mode_reg      <= 1'b0;
      neg_reg       <= 1'b0;
      idx_reg       <= '0;
      miss_seen_reg <= 1'b0;
      miss_lt_reg   <= 1'b0;
      eq_reg        <= 1'b0;
      lt_reg        <= 1'b0;
      result_reg    <= 1'b0;
    end else begin
      case (state_reg)
        IDLE: begin
          if (in_valid) begin
            a_reg         <= a ^ sign_flip;
            b_reg         <= b ^ sign_flip;
            mode_reg      <= op.mode;
            neg_reg       <= op.neg;
            idx_reg       <= '0;
            miss_seen_reg <= 1'b0;
            miss_lt_reg   <= 1'b0;
          end
        end
        SCAN: begin
          if (state_next == DONE) begin
            eq_reg     <= fin_eq;
            lt_reg     <= fin_lt;
            result_reg <= mode_reg ? (fin_lt ^ neg_reg) : (fin_eq ^ neg_reg);
          end else begin
            idx_reg <= idx_reg + IDXW'(1);
            if (slice_diff && !miss_seen_reg) begin
              miss_seen_reg <= 1'b1;
              miss_lt_reg   <= slice_lt;
            end
          end
        end
        default: ;
      endcase
    end
  end

  assign in_ready  = (state_reg == IDLE) && !reset;
  assign out_valid = (state_reg == DONE);
  assign busy      = (state_reg == SCAN);
  assign result    = result_reg;
  assign eq        = eq_reg;
  assign lt        = lt_reg;

endmodule

// File: tb/tb_iterative_compare_unit.sv
// Drives three comparator configurations in lockstep (early-exit 8-bit slices,
// full-scan 8-bit slices, single 32-bit slice) and checks results and latency.

module tb_iterative_compare_unit;

  localparam logic [2:0] OP_EQ  = 3'b000;
  localparam logic [2:0] OP_NE  = 3'b001;
  localparam logic [2:0] OP_LT  = 3'b100;
  localparam logic [2:0] OP_GE  = 3'b101;
  localparam logic [2:0] OP_LTU = 3'b110;
  localparam logic [2:0] OP_GEU = 3'b111;

  logic clk = 1'b0;
  logic reset = 1'b1;
  logic in_valid = 1'b0;
  logic out_ready = 1'b0;
  logic [31:0] a = '0;
  logic [31:0] b = '0;
  Types::comparison_op_t op;
  logic [2:0] ir, ov, res, eqo, lto, bsy;

  int checks = 0;
  int errors = 0;

  always #5 clk = ~clk;

  iterative_compare_unit #(.WIDTH(32), .CHUNK(8), .EARLY_EXIT(1'b1)) dut0 (
    .clk(clk), .reset(reset), .in_valid(in_valid), .in_ready(ir[0]), .a(a), .b(b), .op(op),
    .out_valid(ov[0]), .out_ready(out_ready), .result(res[0]), .eq(eqo[0]), .lt(lto[0]), .busy(bsy[0]));
  iterative_compare_unit #(.WIDTH(32), .CHUNK(8), .EARLY_EXIT(1'b0)) dut1 (
    .clk(clk), .reset(reset), .in_valid(in_valid), .in_ready(ir[1]), .a(a), .b(b), .op(op),
    .out_valid(ov[1]), .out_ready(out_ready), .result(res[1]), .eq(eqo[1]), .lt(lto[1]), .busy(bsy[1]));
  iterative_compare_unit #(.WIDTH(32), .CHUNK(32), .EARLY_EXIT(1'b1)) dut2 (
    .clk(clk), .reset(reset), .in_valid(in_valid), .in_ready(ir[2]), .a(a), .b(b), .op(op),
    .out_valid(ov[2]), .out_ready(out_ready), .result(res[2]), .eq(eqo[2]), .lt(lto[2]), .busy(bsy[2]));

  typedef struct {
    string       name;
    logic [31:0] a;
    logic [31:0] b;
    logic [2:0]  op;
    logic        exp_res;
    logic        exp_eq;
    logic        exp_lt;
    int          exp_lat;  // latency of the early-exit 8-bit configuration
  } vec_t;

  vec_t vecs [11];

  task automatic chk(input string name, input int lane, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s lane %0d: got %0h, expected %0h", name, lane, act, exp);
    end
  endtask

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  // Accept one operation on all lanes, measure latency, check, then hand off.
  task automatic run_op(input vec_t v);
    int lat [3];
    int want_lat [3];
    want_lat[0] = v.exp_lat;
    want_lat[1] = 4;
    want_lat[2] = 1;
    a = v.a; b = v.b; op = v.op; in_valid = 1'b1;
    chk({v.name, " in_ready"}, 9, 32'(ir), 32'h7);
    tick();
    in_valid = 1'b0; a = ~v.a; b = ~v.b; op = ~v.op;
    chk({v.name, " busy"}, 9, 32'(bsy), 32'h7);
    chk({v.name, " out_valid early"}, 9, 32'(ov), 32'h0);
    for (int i = 0; i < 3; i++) lat[i] = -1;
    for (int e = 1; e <= 20 && (lat[0] < 0 || lat[1] < 0 || lat[2] < 0); e++) begin
      tick();
      for (int i = 0; i < 3; i++) if (ov[i] && lat[i] < 0) lat[i] = e;
    end
    for (int i = 0; i < 3; i++) begin
      chk({v.name, " latency"}, i, 32'(lat[i]), 32'(want_lat[i]));
      chk({v.name, " result"}, i, 32'(res[i]), 32'(v.exp_res));
      chk({v.name, " eq"}, i, 32'(eqo[i]), 32'(v.exp_eq));
      chk({v.name, " lt"}, i, 32'(lto[i]), 32'(v.exp_lt));
    end
    out_ready = 1'b1;
    tick();
    out_ready = 1'b0;
    chk({v.name, " handoff out_valid"}, 9, 32'(ov), 32'h0);
    chk({v.name, " handoff in_ready"}, 9, 32'(ir), 32'h7);
    $display("op %-12s a=%08h b=%08h op=%03b -> result %b%b%b lat %0d/%0d/%0d",
             v.name, v.a, v.b, v.op, res[0], res[1], res[2], lat[0], lat[1], lat[2]);
  endtask

  initial begin
    vec_t v;
    int seen;
    vecs[0]  = '{"eq_same",   32'h12345678, 32'h12345678, OP_EQ,  1'b1, 1'b1, 1'b0, 4};
    vecs[1]  = '{"ne_same",   32'h12345678, 32'h12345678, OP_NE,  1'b0, 1'b1, 1'b0, 4};
    vecs[2]  = '{"lt_neg1",   32'hFFFFFFFF, 32'h00000001, OP_LT,  1'b1, 1'b0, 1'b1, 1};
    vecs[3]  = '{"ltu_big",   32'hFFFFFFFF, 32'h00000001, OP_LTU, 1'b0, 1'b0, 1'b0, 1};
    vecs[4]  = '{"geu_big",   32'hFFFFFFFF, 32'h00000001, OP_GEU, 1'b1, 1'b0, 1'b0, 1};
    vecs[5]  = '{"geu_lsb",   32'h00000010, 32'h00000011, OP_GEU, 1'b0, 1'b0, 1'b1, 4};
    vecs[6]  = '{"ge_minint", 32'h80000000, 32'h7FFFFFFF, OP_GE,  1'b0, 1'b0, 1'b1, 1};
    vecs[7]  = '{"ltu_s1",    32'h12340000, 32'h12FF0000, OP_LTU, 1'b1, 1'b0, 1'b1, 2};
    vecs[8]  = '{"eq_s1",     32'h00AB0000, 32'h00AA0000, OP_EQ,  1'b0, 1'b0, 1'b0, 2};
    vecs[9]  = '{"ltu_first", 32'h01000000, 32'h00FFFFFF, OP_LTU, 1'b0, 1'b0, 1'b0, 1};
    vecs[10] = '{"lt_s3",     32'h12345677, 32'h12345678, OP_LT,  1'b1, 1'b0, 1'b1, 4};
    op = OP_EQ;

    // Reset state
    #2;
    chk("reset in_ready", 9, 32'(ir), 32'h0);
    chk("reset outputs", 9, {20'h0, ov, res, eqo, lto}, 32'h0);
    tick(); tick();
    reset = 1'b0;
    #1;
    chk("post-reset in_ready", 9, 32'(ir), 32'h7);
    chk("post-reset busy", 9, 32'(bsy), 32'h0);
    tick();

    for (int i = 0; i < 11; i++) run_op(vecs[i]);

    // Backpressure: hold out_ready low, try to sneak in a new request
    v = vecs[7];
    a = v.a; b = v.b; op = v.op; in_valid = 1'b1;
    tick();
    in_valid = 1'b0;
    seen = 0;
    for (int e = 0; e < 20 && ov != 3'b111; e++) tick();
    chk("bp out_valid", 9, 32'(ov), 32'h7);
    for (int c = 0; c < 5; c++) begin
      in_valid = 1'b1; a = 32'h5; b = 32'h5; op = OP_EQ;
      tick();
      chk("bp result", 9, 32'(res), 32'h7);
      chk("bp eq", 9, 32'(eqo), 32'h0);
      chk("bp lt", 9, 32'(lto), 32'h7);
      chk("bp in_ready", 9, 32'(ir), 32'h0);
      chk("bp out_valid held", 9, 32'(ov), 32'h7);
    end
    in_valid = 1'b0;
    out_ready = 1'b1;
    tick();
    out_ready = 1'b0;
    chk("bp release in_ready", 9, 32'(ir), 32'h7);
    chk("bp release out_valid", 9, 32'(ov), 32'h0);
    chk("bp release result", 9, 32'(res), 32'h7);
    tick(); tick();
    chk("bp ignored request", 9, {29'h0, ov | bsy}, 32'h0);
    $display("seq backpressure result %b%b%b in_ready %b%b%b", res[0], res[1], res[2], ir[0], ir[1], ir[2]);

    // Reset in the middle of a 4-slice compare
    a = 32'h12345678; b = 32'h12345678; op = OP_EQ; in_valid = 1'b1;
    tick();
    in_valid = 1'b0;
    tick(); tick();
    reset = 1'b1;
    #1;
    chk("abort outputs", 9, {17'h0, ov, res, eqo, lto, bsy}, 32'h0);
    chk("abort in_ready", 9, 32'(ir), 32'h0);
    tick();
    reset = 1'b0;
    #1;
    chk("abort recover in_ready", 9, 32'(ir), 32'h7);
    for (int c = 0; c < 6; c++) begin
      tick();
      if (ov != 3'b000) seen = 1;
    end
    chk("abort no out_valid", 9, 32'(seen), 32'h0);
    $display("seq reset-abort out_valid_seen %0d", seen);
    v = '{"eq_after_rst", 32'h5, 32'h5, OP_EQ, 1'b1, 1'b1, 1'b0, 4};
    run_op(v);

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
